// File: rtl/osfm_pkg.sv
// osfm_pkg: shared widths and operand/slice/product types for the OSFM datapath
package osfm_pkg;
    localparam int BITWIDTH        = 16;
    localparam int OSFM_BITWIDTH_I = 8;
    localparam int SHIFTDISTANCE   = BITWIDTH - OSFM_BITWIDTH_I;

    typedef logic signed [BITWIDTH-1:0]          op_t;
    typedef logic signed [OSFM_BITWIDTH_I-1:0]   slice_t;
    typedef logic signed [2*OSFM_BITWIDTH_I-1:0] prod_t;
    typedef logic [1:0]                          flags_t;
endpackage

// File: rtl/osfm_lowinput_detector.sv
// osfm_lowinput_detector: flags a sign-extended (low) operand and picks its LSB or MSB slice
module osfm_lowinput_detector
    import osfm_pkg::*;
(
    input  op_t    op,
    output logic   low,
    output slice_t slice
);
    logic [SHIFTDISTANCE:0] top;

    // The operand is low when its upper SHIFTDISTANCE+1 bits are pure sign extension
    always_comb begin
        top   = op[BITWIDTH-1:OSFM_BITWIDTH_I-1];
        low   = (&top) | ~(|top);
        slice = low ? op[OSFM_BITWIDTH_I-1:0] : op[BITWIDTH-1:SHIFTDISTANCE];
    end
endmodule

// File: rtl/osfm_operand_pipe.sv
// osfm_operand_pipe: elastic two-stage slice-select and signed multiply front end (OSFM_STATS_EN adds lowcount)
module osfm_operand_pipe
    import osfm_pkg::*;
(
    input  logic   clk,
    input  logic   rst_n,
    input  logic   in_valid,
    output logic   in_ready,
    input  op_t    op_a,
    input  op_t    op_b,
    output logic   out_valid,
    input  logic   out_ready,
    output prod_t  shiftin,
    output flags_t shift_possible
`ifdef OSFM_STATS_EN
    ,
    output logic [31:0] lowcount
`endif
);
    logic   low_a, low_b;
    slice_t sel_a, sel_b;
    slice_t s1_a, s1_b;
    flags_t s1_flags;
    logic   s1_valid;
    prod_t  s2_prod;
    flags_t s2_flags;
    logic   s2_valid;
    logic   s2_load, s1_load;

    osfm_lowinput_detector u_det_a (.op(op_a), .low(low_a), .slice(sel_a));
    osfm_lowinput_detector u_det_b (.op(op_b), .low(low_b), .slice(sel_b));

    assign s2_load        = !s2_valid || out_ready;
    assign in_ready       = !s1_valid || s2_load;
    assign s1_load        = in_valid && in_ready;
    assign out_valid      = s2_valid;
    assign shiftin        = s2_prod;
    assign shift_possible = s2_flags;

    // Stage 1 captures the selected slices and low flags on input transfer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_flags <= '0;
        end else begin
            if (in_ready) s1_valid <= in_valid;
            if (s1_load) begin
                s1_a     <= sel_a;
                s1_b     <= sel_b;
                s1_flags <= {low_b, low_a};
            end
        end
    end

    // Stage 2 forms the full-width signed product; data moves only when stage 1 holds a pair
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            s2_prod  <= '0;
            s2_flags <= '0;
        end else begin
            if (s2_load) s2_valid <= s1_valid;
            if (s2_load && s1_valid) begin
                s2_prod  <= prod_t'(s1_a) * prod_t'(s1_b);
                s2_flags <= s1_flags;
            end
        end
    end

`ifdef OSFM_STATS_EN
    // Saturating count of delivered products that had at least one low operand
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) lowcount <= '0;
        else if (out_valid && out_ready && |s2_flags && lowcount != 32'hFFFF_FFFF)
            lowcount <= lowcount + 32'd1;
    end
`endif
endmodule

// File: tb/tb_osfm_operand_pipe.sv
// tb_osfm_operand_pipe: directed and scoreboard checks for the OSFM operand pipe
module tb_osfm_operand_pipe;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] op_a, op_b;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] shiftin;
    logic [1:0]  shift_possible;
`ifdef OSFM_STATS_EN
    logic [31:0] lowcount;
`endif
    int pass_cnt = 0;
    int total = 0;

    osfm_operand_pipe dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .op_a(op_a), .op_b(op_b), .out_valid(out_valid), .out_ready(out_ready),
        .shiftin(shiftin), .shift_possible(shift_possible)
`ifdef OSFM_STATS_EN
        , .lowcount(lowcount)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, actual=timeout required=finish");
        $fatal(1);
    end

    // Reference: low iff value fits in -128..127; product of the chosen signed slices
    function automatic logic [17:0] model(input logic [15:0] a, input logic [15:0] b);
        int va, vb, xa, xb;
        logic signed [7:0] t;
        logic la, lb;
        logic [31:0] p;
        va = int'($signed(a));
        vb = int'($signed(b));
        la = (va >= -128) && (va <= 127);
        lb = (vb >= -128) && (vb <= 127);
        t = la ? a[7:0] : a[15:8];
        xa = int'(t);
        t = lb ? b[7:0] : b[15:8];
        xb = int'(t);
        p = 32'(xa * xb);
        return {lb, la, p[15:0]};
    endfunction

    task test_reset;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; op_a = '0; op_b = '0;
        #2;
        total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid actual=%b required=0", out_valid); else pass_cnt++;
        total++; if (shiftin !== 16'h0) $display("FAIL reset_shiftin actual=%h required=0000", shiftin); else pass_cnt++;
        total++; if (shift_possible !== 2'b00) $display("FAIL reset_flags actual=%b required=00", shift_possible); else pass_cnt++;
        total++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready actual=%b required=1", in_ready); else pass_cnt++;
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
    endtask

    task test_basic;
        logic [15:0] va [9] = '{16'h0300, 16'h0005, 16'h0300, 16'hFFFE, 16'hFF80, 16'hFF80, 16'h0080, 16'h7FFF, 16'h0080};
        logic [15:0] vb [9] = '{16'h0200, 16'h0300, 16'h0005, 16'hFFFD, 16'hFF80, 16'h0300, 16'h0300, 16'h8000, 16'h0005};
        logic [15:0] ep [9] = '{16'h0006, 16'h000F, 16'h000F, 16'h0006, 16'h4000, 16'hFE80, 16'h0000, 16'hC080, 16'h0000};
        logic [1:0]  ef [9] = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b11, 2'b01, 2'b00, 2'b00, 2'b10};
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            out_ready = 1'b1; in_valid = 1'b1; op_a = va[i]; op_b = vb[i];
            @(negedge clk);
            in_valid = 1'b0;
            @(posedge clk); #1;
            total++; if (out_valid !== 1'b1) $display("FAIL basic%0d_valid actual=%b required=1", i, out_valid); else pass_cnt++;
            total++; if (shiftin !== ep[i]) $display("FAIL basic%0d_shiftin actual=%h required=%h", i, shiftin, ep[i]); else pass_cnt++;
            total++; if (shift_possible !== ef[i]) $display("FAIL basic%0d_flags actual=%b required=%b", i, shift_possible, ef[i]); else pass_cnt++;
        end
        @(negedge clk);
    endtask

    task test_stall;
        @(negedge clk);
        out_ready = 1'b0; in_valid = 1'b1; op_a = 16'h0300; op_b = 16'h0200;
        @(negedge clk);
        total++; if (in_ready !== 1'b1) $display("FAIL stall_second_ready actual=%b required=1", in_ready); else pass_cnt++;
        op_a = 16'h0005; op_b = 16'h0300;
        @(negedge clk);
        op_a = 16'hFFFE; op_b = 16'hFFFD;
        #1;
        total++; if (in_ready !== 1'b0) $display("FAIL stall_full_ready actual=%b required=0", in_ready); else pass_cnt++;
        total++; if (out_valid !== 1'b1) $display("FAIL stall_valid actual=%b required=1", out_valid); else pass_cnt++;
        total++; if (shiftin !== 16'h0006) $display("FAIL stall_shiftin actual=%h required=0006", shiftin); else pass_cnt++;
        @(negedge clk);
        total++; if (shiftin !== 16'h0006) $display("FAIL stall_hold_shiftin actual=%h required=0006", shiftin); else pass_cnt++;
        total++; if (shift_possible !== 2'b00) $display("FAIL stall_hold_flags actual=%b required=00", shift_possible); else pass_cnt++;
        total++; if (in_ready !== 1'b0) $display("FAIL stall_hold_ready actual=%b required=0", in_ready); else pass_cnt++;
        out_ready = 1'b1;
        #1;
        total++; if (in_ready !== 1'b1) $display("FAIL stall_release_ready actual=%b required=1", in_ready); else pass_cnt++;
        @(negedge clk);
        in_valid = 1'b0;
        total++; if (out_valid !== 1'b1 || shiftin !== 16'h000F || shift_possible !== 2'b01)
            $display("FAIL drain1 actual=%b/%h/%b required=1/000F/01", out_valid, shiftin, shift_possible); else pass_cnt++;
        @(negedge clk);
        total++; if (out_valid !== 1'b1 || shiftin !== 16'h0006 || shift_possible !== 2'b11)
            $display("FAIL drain2 actual=%b/%h/%b required=1/0006/11", out_valid, shiftin, shift_possible); else pass_cnt++;
        @(negedge clk);
        total++; if (out_valid !== 1'b0) $display("FAIL drain_empty actual=%b required=0", out_valid); else pass_cnt++;
    endtask

    task test_stream;
        logic [17:0] q[$];
        logic [17:0] e;
        logic [31:0] r;
        logic hold;
        hold = 1'b0;
        for (int c = 0; c < 410; c++) begin
            @(negedge clk);
            if (c >= 400) begin
                in_valid = 1'b0; out_ready = 1'b1;
            end else begin
                if (!hold) begin
                    in_valid = ($urandom % 4) != 0;
                    r = $urandom;
                    op_a = r[16] ? {{9{r[7]}}, r[6:0]} : r[15:0];
                    r = $urandom;
                    op_b = r[16] ? {{9{r[7]}}, r[6:0]} : r[15:0];
                end
                out_ready = ($urandom % 3) != 0;
            end
            #1;
            hold = in_valid && !in_ready;
            if (in_valid && in_ready) q.push_back(model(op_a, op_b));
            if (out_valid && out_ready) begin
                total++;
                if (q.size() == 0) $display("FAIL stream_extra actual=%h required=none", shiftin);
                else begin
                    e = q.pop_front();
                    if ({shift_possible, shiftin} !== e)
                        $display("FAIL stream_item actual=%b/%h required=%b/%h", shift_possible, shiftin, e[17:16], e[15:0]);
                    else pass_cnt++;
                end
            end
        end
        total++; if (q.size() != 0) $display("FAIL stream_lost actual=%0d required=0", q.size()); else pass_cnt++;
    endtask

    task test_async_reset;
        @(negedge clk);
        out_ready = 1'b0; in_valid = 1'b1; op_a = 16'h0300; op_b = 16'h0200;
        @(negedge clk);
        op_a = 16'hFFFE; op_b = 16'hFFFD;
        @(negedge clk);
        in_valid = 1'b0;
        total++; if (out_valid !== 1'b1 || in_ready !== 1'b0) $display("FAIL areset_full actual=%b/%b required=1/0", out_valid, in_ready); else pass_cnt++;
        #2 rst_n = 1'b0;
        #1;
        total++; if (out_valid !== 1'b0) $display("FAIL areset_valid actual=%b required=0", out_valid); else pass_cnt++;
        total++; if (shiftin !== 16'h0 || shift_possible !== 2'b00) $display("FAIL areset_data actual=%h/%b required=0000/00", shiftin, shift_possible); else pass_cnt++;
        total++; if (in_ready !== 1'b1) $display("FAIL areset_ready actual=%b required=1", in_ready); else pass_cnt++;
        @(negedge clk);
        rst_n = 1'b1; out_ready = 1'b1;
        @(negedge clk); @(negedge clk); @(negedge clk);
        total++; if (out_valid !== 1'b0 || shiftin !== 16'h0) $display("FAIL areset_discard actual=%b/%h required=0/0000", out_valid, shiftin); else pass_cnt++;
    endtask

`ifdef OSFM_STATS_EN
    task test_stats;
        logic [15:0] sa [5] = '{16'h0300, 16'h0005, 16'h0300, 16'hFFFE, 16'h0300};
        logic [15:0] sb [5] = '{16'h0200, 16'h0300, 16'h0200, 16'hFFFD, 16'h0005};
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        total++; if (lowcount !== 32'd0) $display("FAIL stats_reset actual=%0d required=0", lowcount); else pass_cnt++;
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; op_a = sa[i]; op_b = sb[i];
            @(negedge clk);
        end
        in_valid = 1'b0;
        @(negedge clk); @(negedge clk); @(negedge clk);
        total++; if (lowcount !== 32'd3) $display("FAIL stats_count actual=%0d required=3", lowcount); else pass_cnt++;
    endtask
`endif

    initial begin
        test_reset;
        test_basic;
        test_stall;
        test_stream;
        test_async_reset;
`ifdef OSFM_STATS_EN
        test_stats;
`endif
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule
